// File: rtl/led_owner_arbiter.sv
// rtl/led_owner_arbiter.sv - fixed-priority owner arbiter for the 16 front-panel LEDs
//
// Picks one of N_SRC pattern sources to drive the LEDs. Source 0 (error) has
// the highest priority and preempts at once; every other ownership lasts at
// least MIN_HOLD cycles so a pattern stays readable.
//
// Optional feature macro: LED_ARB_BLANK_EN
//   When defined, every hand-over between two different sources passes through
//   GAP_CYCLES blank cycles (LEDs dark, no grant).
//
// Ports:
//   clock         system clock (40 MHz)
//   reset         asynchronous, active-high reset
//   req           per-source level request
//   led_src       source i pattern at bits [16*i+15:16*i]
//   led_out       registered LED drive
//   grant         one-hot current owner, zero when idle or blanking
//   active        OR of grant
//   switch_count  saturating count of ownership changes
module led_owner_arbiter #(
  parameter int          N_SRC        = 4,
  parameter int          MIN_HOLD     = 10019750,
  parameter int          HOLD_W       = 24,
  parameter int          GAP_CYCLES   = 4007900,
  parameter logic [15:0] IDLE_PATTERN = 16'h0000
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [N_SRC-1:0]     req,
  input  logic [16*N_SRC-1:0]  led_src,
  output logic [15:0]          led_out,
  output logic [N_SRC-1:0]     grant,
  output logic                 active,
  output logic [15:0]          switch_count
);

  localparam int IDX_W = $clog2(N_SRC);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_OWN   = 2'd1;
`ifdef LED_ARB_BLANK_EN
  localparam logic [1:0] ST_BLANK = 2'd2;
  localparam logic [HOLD_W-1:0] GAP_LOAD = HOLD_W'(GAP_CYCLES - 1);
`endif

  localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(MIN_HOLD - 1);

  logic [1:0]        state, state_nxt;
  logic [IDX_W-1:0]  owner, owner_nxt;
  logic [HOLD_W-1:0] hold, hold_nxt;
`ifdef LED_ARB_BLANK_EN
  logic [HOLD_W-1:0] gap, gap_nxt;
`endif

  logic              any_req;
  logic [IDX_W-1:0]  win;
  logic              hold_zero;
  logic              rearb;
  logic              changed;
  logic [15:0]       pat_sel;
  logic [15:0]       led_nxt;
  logic [N_SRC-1:0]  grant_nxt;

  // Lowest requesting index wins; scanning downward leaves the lowest one.
  always_comb begin
    any_req = |req;
    win     = '0;
    for (int i = N_SRC - 1; i >= 0; i--) begin
      if (req[i]) win = IDX_W'(i);
    end
  end

  // Source 0 cuts in regardless of hold; anyone else waits for hold to run out.
  assign hold_zero = (hold == '0);
  assign rearb = (req[0] && (owner != '0)) ||
                 (hold_zero && (!req[owner] || (any_req && (win < owner))));

  always_comb begin
    state_nxt = state;
    owner_nxt = owner;
    hold_nxt  = hold;
    changed   = 1'b0;
`ifdef LED_ARB_BLANK_EN
    gap_nxt   = gap;
`endif
    case (state)
      ST_IDLE: begin
        if (any_req) begin
          state_nxt = ST_OWN;
          owner_nxt = win;
          hold_nxt  = HOLD_LOAD;
          changed   = 1'b1;
        end
      end
      ST_OWN: begin
        hold_nxt = hold_zero ? '0 : hold - HOLD_W'(1);
        if (rearb) begin
          if (!any_req) begin
            state_nxt = ST_IDLE;
            changed   = 1'b1;
          end else if (win != owner) begin
`ifdef LED_ARB_BLANK_EN
            // The count is bumped when BLANK resolves, not here.
            state_nxt = ST_BLANK;
            gap_nxt   = GAP_LOAD;
`else
            owner_nxt = win;
            hold_nxt  = HOLD_LOAD;
            changed   = 1'b1;
`endif
          end
        end
      end
`ifdef LED_ARB_BLANK_EN
      ST_BLANK: begin
        // The gap always runs to completion, even for source 0.
        if (gap == '0) begin
          changed = 1'b1;
          if (any_req) begin
            state_nxt = ST_OWN;
            owner_nxt = win;
            hold_nxt  = HOLD_LOAD;
          end else begin
            state_nxt = ST_IDLE;
          end
        end else begin
          gap_nxt = gap - HOLD_W'(1);
        end
      end
`endif
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Outputs follow the next state so grant and pattern move on the same edge.
  always_comb begin
    pat_sel   = '0;
    grant_nxt = '0;
    for (int i = 0; i < N_SRC; i++) begin
      if (owner_nxt == IDX_W'(i)) begin
        pat_sel      = led_src[16*i +: 16];
        grant_nxt[i] = (state_nxt == ST_OWN);
      end
    end
    if (state_nxt == ST_OWN) begin
      led_nxt = pat_sel;
    end else if (state_nxt == ST_IDLE) begin
      led_nxt = IDLE_PATTERN;
    end else begin
      led_nxt = 16'h0000;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= ST_IDLE;
      owner        <= '0;
      hold         <= '0;
`ifdef LED_ARB_BLANK_EN
      gap          <= '0;
`endif
      led_out      <= IDLE_PATTERN;
      grant        <= '0;
      active       <= 1'b0;
      switch_count <= '0;
    end else begin
      state   <= state_nxt;
      owner   <= owner_nxt;
      hold    <= hold_nxt;
`ifdef LED_ARB_BLANK_EN
      gap     <= gap_nxt;
`endif
      led_out <= led_nxt;
      grant   <= grant_nxt;
      active  <= |grant_nxt;
      if (changed && (switch_count != 16'hFFFF)) begin
        switch_count <= switch_count + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_led_owner_arbiter.sv
// tb/tb_led_owner_arbiter.sv - scoreboard bench for led_owner_arbiter
module tb_led_owner_arbiter;

  localparam int          N    = 4;
  localparam int          MH   = 8;
  localparam int          GAP  = 3;
  localparam logic [15:0] IDLE = 16'h5A5A;

  logic        clock = 1'b0;
  logic        reset;
  logic [3:0]  req;
  logic [63:0] led_src;
  logic [15:0] led_out;
  logic [3:0]  grant;
  logic        active;
  logic [15:0] switch_count;

  logic        rst2;
  logic [1:0]  req2;
  logic [31:0] led_src2;
  logic [15:0] led_out2;
  logic [1:0]  grant2;
  logic        active2;
  logic [15:0] switch_count2;

  logic        sat_done;

  always #5 clock = ~clock;

  led_owner_arbiter #(
    .N_SRC(N), .MIN_HOLD(MH), .HOLD_W(8), .GAP_CYCLES(GAP), .IDLE_PATTERN(IDLE)
  ) dut (
    .clock(clock), .reset(reset), .req(req), .led_src(led_src),
    .led_out(led_out), .grant(grant), .active(active), .switch_count(switch_count)
  );

  led_owner_arbiter #(
    .N_SRC(2), .MIN_HOLD(1), .HOLD_W(4), .GAP_CYCLES(1), .IDLE_PATTERN(16'h0000)
  ) dut_sat (
    .clock(clock), .reset(rst2), .req(req2), .led_src(led_src2),
    .led_out(led_out2), .grant(grant2), .active(active2), .switch_count(switch_count2)
  );

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [15:0] led;
    logic [3:0]  grant;
    logic        active;
    logic [15:0] cnt;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: ownership tracked by owner index and the cycle it began.
  int m_owner;
  int m_gcyc;
  int m_bstart;
  int m_cnt;
  int m_cyc;
  bit m_blank;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  function automatic int winner(input logic [3:0] r);
    for (int i = 0; i < N; i++) if (r[i]) return i;
    return -1;
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_blank = 1'b0;
    m_cnt   = 0;
    m_cyc   = 0;
    m_gcyc  = 0;
    m_bstart = 0;
  endtask

  task automatic bump();
    if (m_cnt < 65535) m_cnt++;
  endtask

  // Drives one cycle of inputs and queues what the DUT must show after the edge.
  task automatic drive(input logic [3:0] r, input logic [63:0] p);
    int   w;
    bit   expired;
    bit   need;
    exp_t e;
    req     = r;
    led_src = p;
    m_cyc++;
    w = winner(r);
    if (m_blank) begin
      if (m_cyc - m_bstart >= GAP) begin
        m_blank = 1'b0;
        m_owner = w;
        m_gcyc  = m_cyc;
        bump();
      end
    end else if (m_owner < 0) begin
      if (w >= 0) begin
        m_owner = w;
        m_gcyc  = m_cyc;
        bump();
      end
    end else begin
      expired = (m_cyc - m_gcyc) >= MH;
      need = (r[0] && m_owner != 0) || (expired && (!r[m_owner] || w < m_owner));
      if (need && w != m_owner) begin
        if (w < 0) begin
          m_owner = -1;
          bump();
        end
`ifdef LED_ARB_BLANK_EN
        else begin
          m_blank  = 1'b1;
          m_bstart = m_cyc;
        end
`else
        else begin
          m_owner = w;
          m_gcyc  = m_cyc;
          bump();
        end
`endif
      end
    end
    e.cnt = m_cnt[15:0];
    if (m_blank) begin
      e.led   = 16'h0000;
      e.grant = 4'b0000;
    end else if (m_owner < 0) begin
      e.led   = IDLE;
      e.grant = 4'b0000;
    end else begin
      e.led   = p[16*m_owner +: 16];
      e.grant = 4'b0001 << m_owner;
    end
    e.active = (e.grant != 4'b0000);
    exp_q.push_back(e);
  endtask

  task automatic rand_step(inout logic [3:0] cur);
    logic [2:0]  hi;
    logic [63:0] p;
    if ($urandom_range(0, 5) == 0) begin
      hi  = 3'($urandom_range(0, 7));
      cur = {hi, ($urandom_range(0, 3) == 0)};
    end
    p = {$urandom, $urandom};
    drive(cur, p);
  endtask

  // Monitor: every edge with a pending expectation is compared.
  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clock);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("led_out", 32'(led_out), 32'(e.led));
        chk("grant", 32'(grant), 32'(e.grant));
        chk("active", 32'(active), 32'(e.active));
        chk("switch_count", 32'(switch_count), 32'(e.cnt));
      end
    end
  end

  initial begin : main_stim
    logic [3:0]  cur;
    logic [63:0] pd;
    reset   = 1'b1;
    req     = '0;
    led_src = '0;
    cur     = '0;
    pd      = 64'h4444_3333_ABCD_1111;
    model_reset();
    repeat (2) @(negedge clock);
    chk("reset_led", 32'(led_out), 32'(IDLE));
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_active", 32'(active), 32'd0);
    chk("reset_count", 32'(switch_count), 32'd0);
    reset = 1'b0;
    drive(cur, {$urandom, $urandom});
    for (int i = 0; i < 1200; i++) begin
      @(negedge clock);
      rand_step(cur);
    end
    // Settle on source 1 showing ABCD, then reset mid-ownership.
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      drive(4'b0010, pd);
    end
    @(posedge clock);
    #3 reset = 1'b1;
    #1;
    chk("async_led", 32'(led_out), 32'(IDLE));
    chk("async_grant", 32'(grant), 32'd0);
    chk("async_active", 32'(active), 32'd0);
    chk("async_count", 32'(switch_count), 32'd0);
    model_reset();
    @(negedge clock);
    reset = 1'b0;
    drive(4'b0010, pd);
    // Source 0 pulses for one cycle, then everything drops.
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      drive(4'b0000, {$urandom, $urandom});
    end
    @(negedge clock);
    drive(4'b0001, {$urandom, $urandom});
    for (int i = 0; i < 12; i++) begin
      @(negedge clock);
      drive(4'b0000, {$urandom, $urandom});
    end
    cur = '0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clock);
      rand_step(cur);
    end
    @(negedge clock);
    req = '0;
    wait (sat_done === 1'b1);
    @(posedge clock);
    #2;
    chk("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Second instance: alternating request/no-request gives one ownership
  // change per cycle, walking switch_count into saturation.
  initial begin : sat_stim
    sat_done = 1'b0;
    rst2     = 1'b1;
    req2     = '0;
    led_src2 = 32'h1234_8765;
    repeat (2) @(negedge clock);
    rst2 = 1'b0;
    for (int k = 1; k <= 65537; k++) begin
      req2 = k[0] ? 2'b01 : 2'b00;
      @(posedge clock);
      #1;
      if (k == 1) begin
        chk("sat_first_grant", 32'(grant2), 32'd1);
        chk("sat_first_led", 32'(led_out2), 32'h8765);
        chk("sat_first_count", 32'(switch_count2), 32'd1);
      end
      if (k == 2) begin
        chk("sat_idle_grant", 32'(grant2), 32'd0);
        chk("sat_idle_count", 32'(switch_count2), 32'd2);
      end
      if (k == 65534) chk("sat_fffe", 32'(switch_count2), 32'h0000FFFE);
      if (k >= 65535) chk("sat_ffff", 32'(switch_count2), 32'h0000FFFF);
      @(negedge clock);
    end
    sat_done = 1'b1;
  end

endmodule
